// File: rtl/uart_rx_top.sv
// UART receiver: 16x-oversampled start/data/parity/stop framing with mid-bit sampling.
// Define UART_RX_SYNC_EN to put a two-flop synchronizer on rx ahead of the FSM.
module uart_rx_top (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic [1:0] wls,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi
);

  typedef enum logic [2:0] {StIdle, StStart, StRead, StParity, StStop} state_e;

  state_e      state_q;
  logic [3:0]  count_q;
  logic [2:0]  bitcnt_q;
  logic [7:0]  data_q;
  logic [1:0]  wls_q;
  logic        pen_q, eps_q, stick_q, par_q;
  logic        rx_s;
  logic [2:0]  bit_idx;
  logic        exp_par;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_q;

  // Two-flop synchronizer; resets to the idle line level so no false start appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync_q <= 2'b11;
    else     rx_sync_q <= {rx_sync_q[0], rx};
  end
  assign rx_s = rx_sync_q[1];
`else
  assign rx_s = rx;
`endif

  // Bit position and expected parity derived from the per-frame captured LCR settings.
  always_comb begin
    bit_idx = {1'b0, wls_q} + 3'd4 - bitcnt_q;
    // Unused upper data bits are held at 0, so a full-width XOR covers only the live bits.
    unique case ({stick_q, eps_q})
      2'b00:   exp_par = ~^data_q;
      2'b01:   exp_par = ^data_q;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // Frame FSM; everything advances only on baud_pulse, push is a single-clk strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= 4'd0;
      bitcnt_q <= 3'd0;
      data_q   <= 8'h00;
      wls_q    <= 2'b00;
      pen_q    <= 1'b0;
      eps_q    <= 1'b0;
      stick_q  <= 1'b0;
      par_q    <= 1'b0;
      push     <= 1'b0;
      dout     <= 8'h00;
      pe       <= 1'b0;
      fe       <= 1'b0;
      bi       <= 1'b0;
    end else begin
      push <= 1'b0;
      if (baud_pulse) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s) begin
              state_q <= StStart;
              count_q <= 4'd7;
            end
          end
          StStart: begin
            if (count_q == 4'd0) begin
              if (!rx_s) begin
                state_q  <= StRead;
                count_q  <= 4'd15;
                bitcnt_q <= {1'b0, wls} + 3'd4;
                data_q   <= 8'h00;
                wls_q    <= wls;
                pen_q    <= pen;
                eps_q    <= eps;
                stick_q  <= sticky_parity;
                par_q    <= 1'b0;
              end else begin
                state_q <= StIdle;  // glitch, not a real start bit
              end
            end else begin
              count_q <= count_q - 4'd1;
            end
          end
          StRead: begin
            if (count_q == 4'd0) begin
              data_q[bit_idx] <= rx_s;
              count_q         <= 4'd15;
              if (bitcnt_q == 3'd0) state_q <= pen_q ? StParity : StStop;
              else                  bitcnt_q <= bitcnt_q - 3'd1;
            end else begin
              count_q <= count_q - 4'd1;
            end
          end
          StParity: begin
            if (count_q == 4'd0) begin
              par_q   <= rx_s;
              count_q <= 4'd15;
              state_q <= StStop;
            end else begin
              count_q <= count_q - 4'd1;
            end
          end
          StStop: begin
            if (count_q == 4'd0) begin
              push    <= 1'b1;
              dout    <= data_q;
              pe      <= pen_q & (par_q != exp_par);
              fe      <= ~rx_s;
              bi      <= (data_q == 8'h00) & ~(pen_q & par_q) & ~rx_s;
              state_q <= StIdle;
            end else begin
              count_q <= count_q - 4'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
